l1_l2_arbiter: RTL and testbench

- Sits between the split L1 caches and the single L2 port: downstream of the icache's `L2_address`/`L2_rdata` interface and of the dcache's miss/writeback interface.
- Accepts line-granularity read requests from the icache and read/write requests from the dcache, and serialises them onto one L2 port.
- Grants fairly on simultaneous misses, holds the grant until L2 responds, and routes the response back to the winner only.

---
 rtl/l1_l2_arbiter.sv | 135 +++++++++++++
 tb/tb_l1_l2_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l1_l2_arbiter
// Purpose  : Serialises icache line reads and dcache line reads/writebacks
//            onto a single L2 port. Simultaneous requests are granted
//            alternately; the grant is held until L2 completes and the
//            completion pulse is routed to the winner only.
// Revision : 1.0 - initial release
// ============================================================================
module l1_l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  // icache side
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  // dcache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  // L2 side
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic                  l2_resp,
  input  logic [LINE_WIDTH-1:0] l2_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_last_d;   // 1: last grant went to dcache
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LINE_WIDTH-1:0]   r_wdata;
  logic                    r_write;

  logic                    w_i_req;
  logic                    w_d_req;
  logic                    w_grant_i;
  logic                    w_grant_d;
  logic                    w_busy;

  // Arbitration: only sampled in IDLE; a tie goes to whoever was not served last
  always_comb begin
    w_i_req   = i_read;
    w_d_req   = d_read | d_write;
    w_grant_d = (r_state == ST_IDLE) && w_d_req && (!w_i_req || !r_last_d);
    w_grant_i = (r_state == ST_IDLE) && w_i_req && !w_grant_d;
  end

  // Next state and all outputs; L2 is driven purely from latched registers
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != ST_IDLE) && !reset;
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    l2_address  = '0;
    l2_wdata    = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    i_rdata     = l2_rdata;
    d_rdata     = l2_rdata;

    if (w_busy) begin
      l2_read    = !r_write;
      l2_write   = r_write;
      l2_address = r_addr;
      l2_wdata   = r_wdata;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_SERVE_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_SERVE_I;
        end
      end
      ST_SERVE_I: begin
        if (l2_resp) begin
          i_resp      = !reset;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVE_D: begin
        if (l2_resp) begin
          d_resp      = !reset;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and request latch, captured on the granting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_last_d <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_d) begin
        r_addr   <= d_address;
        r_wdata  <= d_wdata;
        r_write  <= d_write;   // write wins when both ops are asserted
        r_last_d <= 1'b1;
      end else if (w_grant_i) begin
        r_addr   <= i_address;
        r_wdata  <= '0;
        r_write  <= 1'b0;
        r_last_d <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_l2_arbiter
// Purpose  : Self-checking bench for l1_l2_arbiter: directed vector table,
//            alternating-tie sequence and constrained-random traffic checked
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  typedef struct {
    logic          rst;
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [LW-1:0] dwd;
    logic          l2r;
    logic [LW-1:0] l2d;
    logic          e_rd;
    logic          e_wr;
    logic [AW-1:0] e_a;
    logic [LW-1:0] e_wd;
    logic          e_ir;
    logic          e_dr;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic          l2_resp;
  logic [LW-1:0] l2_rdata;

  int n_pass;
  int n_total;

  l1_l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_resp     (i_resp),
    .i_rdata    (i_rdata),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_resp     (d_resp),
    .d_rdata    (d_rdata),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_resp    (l2_resp),
    .l2_rdata   (l2_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic ir, input logic [AW-1:0] ia,
                              input logic dr, input logic dw, input logic [AW-1:0] da,
                              input logic [LW-1:0] dwd, input logic l2r, input logic [LW-1:0] l2d,
                              input logic e_rd, input logic e_wr, input logic [AW-1:0] e_a,
                              input logic [LW-1:0] e_wd, input logic e_ir, input logic e_dr);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.l2r = l2r; v.l2d = l2d; v.e_rd = e_rd; v.e_wr = e_wr; v.e_a = e_a; v.e_wd = e_wd;
    v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  // One clock cycle: drive inputs, compare mid-cycle, advance past the edge
  task automatic run_cycle(input vec_t v, input string tag);
    reset     = v.rst;
    i_read    = v.ir;
    i_address = v.ia;
    d_read    = v.dr;
    d_write   = v.dw;
    d_address = v.da;
    d_wdata   = v.dwd;
    l2_resp   = v.l2r;
    l2_rdata  = v.l2d;
    #3;
    chk({tag, ".l2_read"},    LW'(l2_read),    LW'(v.e_rd));
    chk({tag, ".l2_write"},   LW'(l2_write),   LW'(v.e_wr));
    chk({tag, ".l2_address"}, LW'(l2_address), LW'(v.e_a));
    chk({tag, ".l2_wdata"},   l2_wdata,        v.e_wd);
    chk({tag, ".i_resp"},     LW'(i_resp),     LW'(v.e_ir));
    chk({tag, ".d_resp"},     LW'(d_resp),     LW'(v.e_dr));
    if (v.e_ir) chk({tag, ".i_rdata"}, i_rdata, v.l2d);
    if (v.e_dr) chk({tag, ".d_rdata"}, d_rdata, v.l2d);
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who owns the L2 port and what it carries
  int            m_owner;   // 0 none, 1 icache, 2 dcache
  logic          m_last_d;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wd;
  logic          m_wr;

  function automatic vec_t model_expect(input vec_t v);
    vec_t  o;
    logic  busy;
    o = v;
    busy   = (m_owner != 0) && !v.rst;
    o.e_rd = busy && !m_wr;
    o.e_wr = busy && m_wr;
    o.e_a  = busy ? m_addr : '0;
    o.e_wd = busy ? m_wd : '0;
    o.e_ir = (m_owner == 1) && v.l2r && !v.rst;
    o.e_dr = (m_owner == 2) && v.l2r && !v.rst;
    return o;
  endfunction

  task automatic model_update(input vec_t v);
    int win;
    if (v.rst) begin
      m_owner = 0; m_last_d = 1'b0;
    end else if (m_owner == 0) begin
      win = 0;
      if (v.ir && (v.dr || v.dw)) win = m_last_d ? 1 : 2;
      else if (v.ir)              win = 1;
      else if (v.dr || v.dw)      win = 2;
      if (win == 1) begin
        m_addr = v.ia; m_wd = '0; m_wr = 1'b0; m_last_d = 1'b0;
      end else if (win == 2) begin
        m_addr = v.da; m_wd = v.dwd; m_wr = v.dw; m_last_d = 1'b1;
      end
      m_owner = win;
    end else if (v.l2r) begin
      m_owner = 0;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [LW-1:0] a5, c11, c22, ccc, z;
    vec_t v;
    logic i_act, d_act, d_rd, d_wr, prev_ir, prev_dr;
    logic [AW-1:0] ra_i, ra_d;
    logic [LW-1:0] rwd;
    n_pass = 0; n_total = 0;
    a5 = {16{8'hA5}}; c11 = {8{16'h1111}}; c22 = {8{16'h2222}}; ccc = {16{8'hCC}}; z = '0;

    // rst ir ia         dr dw da         dwd  l2r l2d | rd wr addr       wdata i  d
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, z,   0, z,  1, 0, 16'h1230, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, z,   1, a5, 1, 0, 16'h1230, z,   1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    // first tie after reset goes to dcache, then the held icache request
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h8000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h8000, z,   0, z,  1, 0, 16'h8000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h8000, z,   1, a5, 1, 0, 16'h8000, z,   0, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, z,   0, z,  1, 0, 16'h0040, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, z,   1, c22, 1, 0, 16'h0040, z,  1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    // writeback whose inputs change during service
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h2010, c11, 0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hFFFF, c11, 0, z,  0, 1, 16'h2010, c11, 0, 0));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1, 16'hFFFF, c22, 0, z,  0, 1, 16'h2010, c11, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hFFFF, c22, 1, a5, 0, 1, 16'h2010, c11, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    // reset in the middle of an icache read
    tbl.push_back(mk(0, 1, 16'h3000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h3000, 0, 0, 16'h0000, z,   0, z,  1, 0, 16'h3000, z,   0, 0));
    tbl.push_back(mk(1, 1, 16'h3000, 0, 0, 16'h0000, z,   1, a5, 0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h3000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h3000, 0, 0, 16'h0000, z,   0, z,  1, 0, 16'h3000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h3000, 0, 0, 16'h0000, z,   1, a5, 1, 0, 16'h3000, z,   1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    // spurious L2 response in IDLE
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, z,   1, a5, 0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0500, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0500, 0, 0, 16'h0000, z,   0, z,  1, 0, 16'h0500, z,   0, 0));
    tbl.push_back(mk(0, 1, 16'h0500, 0, 0, 16'h0000, z,   1, c11, 1, 0, 16'h0500, z,  1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));
    // illegal read+write: the write is taken
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h4444, ccc, 0, z,  0, 0, 16'h0000, z,   0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h4444, ccc, 0, z,  0, 1, 16'h4444, ccc, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h4444, ccc, 1, a5, 0, 1, 16'h4444, ccc, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, z,   0, z,  0, 0, 16'h0000, z,   0, 0));

    reset = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; l2_resp = 1'b0; l2_rdata = '0;
    @(posedge clk);
    #1;

    foreach (tbl[k]) run_cycle(tbl[k], $sformatf("vec%0d", k));

    // Four back-to-back ties; last grant was dcache, so icache wins first
    for (int k = 0; k < 4; k++) begin
      logic          win_i;
      logic [AW-1:0] wa;
      win_i = (k % 2 == 0);
      wa    = win_i ? (16'h0100 + AW'(k)) : (16'h9000 + AW'(k));
      v = mk(0, 1, 16'h0100 + AW'(k), 1, 0, 16'h9000 + AW'(k), z, 0, z, 0, 0, 16'h0000, z, 0, 0);
      run_cycle(v, $sformatf("tie%0d.idle", k));
      v.e_rd = 1'b1; v.e_a = wa;
      run_cycle(v, $sformatf("tie%0d.serve", k));
      v.l2r = 1'b1; v.l2d = a5; v.e_ir = win_i; v.e_dr = !win_i;
      run_cycle(v, $sformatf("tie%0d.resp", k));
      v = mk(0, 0, 16'h0000, 0, 0, 16'h0000, z, 0, z, 0, 0, 16'h0000, z, 0, 0);
      run_cycle(v, $sformatf("tie%0d.gap", k));
    end

    // Random traffic obeying the requester contract, against the model
    m_owner = 0; m_last_d = 1'b0; m_addr = '0; m_wd = '0; m_wr = 1'b0;
    v = mk(1, 0, 16'h0000, 0, 0, 16'h0000, z, 0, z, 0, 0, 16'h0000, z, 0, 0);
    v = model_expect(v);
    run_cycle(v, "rnd.reset");
    model_update(v);
    i_act = 1'b0; d_act = 1'b0; d_rd = 1'b0; d_wr = 1'b0; prev_ir = 1'b0; prev_dr = 1'b0;
    ra_i = '0; ra_d = '0; rwd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (i_act && prev_ir) i_act = 1'b0;
      else if (!i_act && ($urandom % 3 == 0)) begin
        i_act = 1'b1; ra_i = AW'($urandom);
      end
      if (d_act && prev_dr) d_act = 1'b0;
      else if (!d_act && ($urandom % 3 == 0)) begin
        d_act = 1'b1; ra_d = AW'($urandom);
        rwd = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom % 8)
          0:       begin d_rd = 1'b1; d_wr = 1'b1; end
          1, 2, 3: begin d_rd = 1'b0; d_wr = 1'b1; end
          default: begin d_rd = 1'b1; d_wr = 1'b0; end
        endcase
      end
      v.rst = ($urandom % 150 == 0);
      v.ir  = i_act; v.ia = ra_i;
      v.dr  = d_act && d_rd; v.dw = d_act && d_wr; v.da = ra_d; v.dwd = rwd;
      v.l2r = ($urandom % 3 == 0);
      v.l2d = {$urandom, $urandom, $urandom, $urandom};
      v = model_expect(v);
      run_cycle(v, $sformatf("rnd%0d", c));
      model_update(v);
      prev_ir = v.e_ir; prev_dr = v.e_dr;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
